prga_encrypt: RTL and testbench
===============================

Name: prga_encrypt

Overview:
ARC4 keystream encryptor, the transmit-side counterpart of the decrypting PRGA.
- Reads a length-prefixed plaintext from plaintext memory and writes the length-prefixed ciphertext to ciphertext memory.
- Runs the ARC4 PRGA over an S memory already initialised and scheduled by the KSA.
- Sits between the S RAM, a plaintext RAM (read-only here) and a ciphertext RAM (write-only here).
- Controlled by the top-level FSM through the en/rdy handshake.

Parameters:
CHECK_PRINTABLE, 1, when 1 the pt_nonprint flag is computed; when 0 pt_nonprint is tied 0

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous and active-low
en  input  1  start request, sampled only when rdy=1
rdy  output  1  high when idle and able to accept en
s_addr  output  8  S RAM address
s_rddata  input  8  S RAM read data, valid the cycle after the address
s_wrdata  output  8  S RAM write data
s_wren  output  1  S RAM write enable
pt_addr  output  8  plaintext RAM address
pt_rddata  input  8  plaintext RAM read data, 1-cycle latency
ct_addr  output  8  ciphertext RAM address
ct_wrdata  output  8  ciphertext RAM write data
ct_wren  output  1  ciphertext RAM write enable
pt_nonprint  output  1  sticky flag: a plaintext byte fell outside 0x20..0x7E during the last run

Behaviour:
- Reset (async, rst_n=0): state IDLE; registers i=0, j=0, k=1, len=0, si=0, sj=0; pt_nonprint=0.
- Reset outputs: rdy=1; all addresses and write data 0; s_wren=0, ct_wren=0.
- Reset mid-run takes effect immediately: write enables drop the same instant; the partial ciphertext in RAM is left as is.
- Memory outputs are combinational from state and registers, default 0. Writes land on the clock edge that ends the state.
- Arithmetic: all 8-bit, mod 256 (natural wrap); no carries kept.
- rdy = (state==IDLE).
- IDLE: pt_addr=0. If en=1, reset i=0, j=0, k=1, clear pt_nonprint, go LEN. en while rdy=0 is ignored.
- LEN: len<=pt_rddata; write ct[0]=pt_rddata (ct_addr=0, ct_wren=1). Go DONE if pt_rddata==0, else I_RD.
- Per byte, 7 states:
  - I_RD: i<=i+1; s_addr=i+1.
  - J_RD: si<=s_rddata; j<=j+s_rddata; s_addr=j+s_rddata.
  - SJ_LAT: sj<=s_rddata; no memory access.
  - WR_J: s_addr=j, s_wrdata=si, s_wren=1.
  - WR_I: s_addr=i, s_wrdata=sj, s_wren=1.
  - PAD_RD: s_addr=si+sj; pt_addr=k.
  - XOR_WR: ct_addr=k, ct_wrdata=s_rddata^pt_rddata, ct_wren=1. If CHECK_PRINTABLE and pt_rddata outside 0x20..0x7E, set pt_nonprint. If k==len go DONE, else k<=k+1 and go I_RD.
- DONE: no access; go IDLE.
- i==j: WR_J then WR_I both write the same value; S is unchanged, which is correct ARC4 behaviour.
- len=255: k reaches 255, compare terminates the run; k never wraps to 0.
- Latency: en accepted at cycle 0 → rdy returns high at cycle 7L+3. L=0 gives cycle 3.
- Exactly one write enable is active per cycle at most. No S read occurs in the same state as an S write.
- en held high continuously starts a new run on each return to IDLE; this is permitted.
- pt_nonprint holds its value until the next accepted start.

Test Plan:
- Length 0: pt[0]=0x00, en pulse → ct[0]=0x00, no S writes, rdy low for cycles 1–2, high at cycle 3.
- Known vector: S scheduled by KSA with key 0x4B6579 ("Key"), pt = 0x09 then "Plaintext". Required: ct[0]=0x09, ct[1..9]=BB F3 16 E8 D9 40 AF 0A D3, rdy high at cycle 66, pt_nonprint=0.
- Round trip: re-run KSA with the same key, feed the encryptor's ct RAM to the decryptor → recovered plaintext equals the original byte-for-byte.
- Non-printable input: pt = 0x02, 0x41, 0x0A → pt_nonprint=1 after the run; cleared on the next en accept. With CHECK_PRINTABLE=0 it stays 0.
- Length 255, random plaintext: 256 ct writes, last to ct_addr=255, matches the software ARC4 model, rdy high at cycle 1788, no k wrap.
- Handshake and reset:
  - en pulsed during the loop is ignored; the byte count is unchanged.
  - rst_n asserted during WR_J forces s_wren=0 and rdy=1 immediately.
  - A subsequent run after reset produces correct output.

Source files
------------

// File: rtl/prga_encrypt.sv
// -----------------------------------------------------------------------------
// prga_encrypt
// ARC4 keystream encryptor. Reads a length-prefixed plaintext from the
// plaintext RAM, runs the ARC4 PRGA over an S RAM that the KSA has already
// scheduled, and writes the length-prefixed ciphertext to the ciphertext RAM.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          start request, only sampled while rdy=1
//   rdy         idle and able to accept en
//   s_addr      S RAM address
//   s_rddata    S RAM read data (valid the cycle after the address)
//   s_wrdata    S RAM write data
//   s_wren      S RAM write enable
//   pt_addr     plaintext RAM address
//   pt_rddata   plaintext RAM read data (1-cycle latency)
//   ct_addr     ciphertext RAM address
//   ct_wrdata   ciphertext RAM write data
//   ct_wren     ciphertext RAM write enable
//   pt_nonprint sticky: a plaintext byte outside 0x20..0x7E was seen in the
//               last run (held 0 when CHECK_PRINTABLE=0)
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | waiting for en; pt_addr parked on the length byte
// LEN      | latch length, copy it to ct[0]
// I_RD     | i <= i+1, read S[i+1]
// J_RD     | si <= S[i], j <= j+S[i], read S[j]
// SJ_LAT   | sj <= S[j]
// WR_J     | S[j] <= si
// WR_I     | S[i] <= sj
// PAD_RD   | read S[si+sj] and pt[k]
// XOR_WR   | ct[k] <= pad ^ pt[k]; finish when k==len
// DONE     | one quiet cycle before returning to IDLE
// -----------------------------------------------------------------------------
module prga_encrypt #(
  parameter bit CHECK_PRINTABLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] ct_addr,
  output logic [7:0] ct_wrdata,
  output logic       ct_wren,
  output logic       pt_nonprint
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN,
    S_I_RD,
    S_J_RD,
    S_SJ_LAT,
    S_WR_J,
    S_WR_I,
    S_PAD_RD,
    S_XOR_WR,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [7:0] r_i;
  logic [7:0] r_j;
  logic [7:0] r_k;
  logic [7:0] r_len;
  logic [7:0] r_si;
  logic [7:0] r_sj;
  logic       r_nonprint;

  logic       w_nonprint_byte;

  assign w_nonprint_byte = CHECK_PRINTABLE &&
                           ((pt_rddata < 8'h20) || (pt_rddata > 8'h7E));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_i        <= 8'h00;
      r_j        <= 8'h00;
      r_k        <= 8'h01;
      r_len      <= 8'h00;
      r_si       <= 8'h00;
      r_sj       <= 8'h00;
      r_nonprint <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_i        <= 8'h00;
            r_j        <= 8'h00;
            r_k        <= 8'h01;
            r_nonprint <= 1'b0;
            r_state    <= S_LEN;
          end
        end
        S_LEN: begin
          r_len   <= pt_rddata;
          r_state <= (pt_rddata == 8'h00) ? S_DONE : S_I_RD;
        end
        S_I_RD: begin
          r_i     <= r_i + 8'h01;
          r_state <= S_J_RD;
        end
        S_J_RD: begin
          r_si    <= s_rddata;
          r_j     <= r_j + s_rddata;
          r_state <= S_SJ_LAT;
        end
        S_SJ_LAT: begin
          r_sj    <= s_rddata;
          r_state <= S_WR_J;
        end
        S_WR_J:   r_state <= S_WR_I;
        S_WR_I:   r_state <= S_PAD_RD;
        S_PAD_RD: r_state <= S_XOR_WR;
        S_XOR_WR: begin
          if (w_nonprint_byte) r_nonprint <= 1'b1;
          // Terminal compare on k: with len=255 the run ends at k=255,
          // so k never wraps back to 0.
          if (r_k == r_len) begin
            r_state <= S_DONE;
          end else begin
            r_k     <= r_k + 8'h01;
            r_state <= S_I_RD;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory ports are decoded combinationally from state so that a reset
  // drops the write enables immediately, not on the next edge.
  always_comb begin
    s_addr    = 8'h00;
    s_wrdata  = 8'h00;
    s_wren    = 1'b0;
    pt_addr   = 8'h00;
    ct_addr   = 8'h00;
    ct_wrdata = 8'h00;
    ct_wren   = 1'b0;
    case (r_state)
      S_LEN: begin
        ct_addr   = 8'h00;
        ct_wrdata = pt_rddata;
        ct_wren   = 1'b1;
      end
      S_I_RD: s_addr = r_i + 8'h01;
      S_J_RD: s_addr = r_j + s_rddata;
      S_WR_J: begin
        s_addr   = r_j;
        s_wrdata = r_si;
        s_wren   = 1'b1;
      end
      S_WR_I: begin
        s_addr   = r_i;
        s_wrdata = r_sj;
        s_wren   = 1'b1;
      end
      S_PAD_RD: begin
        s_addr  = r_si + r_sj;
        pt_addr = r_k;
      end
      S_XOR_WR: begin
        ct_addr   = r_k;
        ct_wrdata = s_rddata ^ pt_rddata;
        ct_wren   = 1'b1;
      end
      default: ;
    endcase
  end

  assign rdy         = (r_state == S_IDLE);
  assign pt_nonprint = CHECK_PRINTABLE ? r_nonprint : 1'b0;

endmodule

// File: tb/tb_prga_encrypt.sv
// -----------------------------------------------------------------------------
// tb_prga_encrypt
// Bench for prga_encrypt. Holds S, plaintext and ciphertext RAMs, a software
// ARC4 model (KSA + PRGA on byte arrays) and a per-cycle compare process.
// A second instance with CHECK_PRINTABLE=0 shares the same read data and
// must track the first one exactly, except that its pt_nonprint stays 0.
// -----------------------------------------------------------------------------
module tb_prga_encrypt;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] pt_addr, pt_rddata;
  logic [7:0] ct_addr, ct_wrdata;
  logic       ct_wren;
  logic       pt_nonprint;

  logic       d1_rdy;
  logic [7:0] d1_s_addr, d1_s_wrdata, d1_pt_addr, d1_ct_addr, d1_ct_wrdata;
  logic       d1_s_wren, d1_ct_wren, d1_pt_nonprint;

  prga_encrypt #(.CHECK_PRINTABLE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren),
    .pt_nonprint(pt_nonprint)
  );

  prga_encrypt #(.CHECK_PRINTABLE(1'b0)) dut_np (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(d1_rdy),
    .s_addr(d1_s_addr), .s_rddata(s_rddata), .s_wrdata(d1_s_wrdata), .s_wren(d1_s_wren),
    .pt_addr(d1_pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(d1_ct_addr), .ct_wrdata(d1_ct_wrdata), .ct_wren(d1_ct_wren),
    .pt_nonprint(d1_pt_nonprint)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAMs with a host load port used only while the DUT is idle
  logic [7:0] s_mem  [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic       h_we;
  logic [7:0] h_addr, h_s, h_pt, h_ct;

  always @(posedge clk) begin
    if (h_we) begin
      s_mem[h_addr]  <= h_s;
      pt_mem[h_addr] <= h_pt;
      ct_mem[h_addr] <= h_ct;
    end else begin
      if (s_wren)  s_mem[s_addr]   <= s_wrdata;
      if (ct_wren) ct_mem[ct_addr] <= ct_wrdata;
    end
    s_rddata  <= s_mem[s_addr];
    pt_rddata <= pt_mem[pt_addr];
  end

  // Model state
  logic [7:0] key    [3] = '{8'h4B, 8'h65, 8'h79};
  logic [7:0] kv     [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] pv     [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] m_s    [256];
  logic [7:0] m_pt   [256];
  logic [7:0] exp_ct [256];
  logic [7:0] rt     [256];
  logic [7:0] exp_len;
  logic       exp_np;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  wr_cnt = 0;
  int  sw_cnt = 0;
  bit  chk_en = 1'b0;
  bit  prev_rdy = 1'b1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  function automatic void model_ksa();
    logic [7:0] j, t;
    j = 8'h00;
    for (int i = 0; i < 256; i++) m_s[i] = 8'(i);
    for (int i = 0; i < 256; i++) begin
      j = j + m_s[i] + key[i % 3];
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
    end
  endfunction

  // Encrypts m_pt with the keystream from m_s; leaves m_s in its final state.
  function automatic void model_run();
    logic [7:0] i, j, t, idx;
    exp_len   = m_pt[0];
    exp_ct[0] = m_pt[0];
    exp_np    = 1'b0;
    i = 8'h00;
    j = 8'h00;
    for (int k = 1; k <= int'(exp_len); k++) begin
      i = i + 8'h01;
      j = j + m_s[i];
      t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
      idx = m_s[i] + m_s[j];
      exp_ct[k] = m_pt[k] ^ m_s[idx];
      if (m_pt[k] < 8'h20 || m_pt[k] > 8'h7E) exp_np = 1'b1;
    end
  endfunction

  task automatic load_mems();
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      h_we   = 1'b1;
      h_addr = 8'(a);
      h_s    = m_s[a];
      h_pt   = m_pt[a];
      h_ct   = 8'hEE;
    end
    @(negedge clk);
    h_we = 1'b0;
  endtask

  task automatic fill_pt(input logic [7:0] len);
    for (int a = 0; a < 256; a++) m_pt[a] = 8'($urandom_range(0, 255));
    m_pt[0] = len;
  endtask

  task automatic run_case(input string nm, input bit pulse, input int exp_lat);
    int n;
    int nbad;
    model_ksa();
    load_mems();
    model_run();
    chk_en = 1'b1;
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    check({nm, "_acc_rdy"}, 32'(rdy), 32'(0));
    check({nm, "_acc_np_clr"}, 32'(pt_nonprint), 32'(0));
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      en = pulse && (n >= 20) && (n <= 22);
      if (rdy) break;
    end
    en = 1'b0;
    check({nm, "_latency"}, 32'(n + 1), 32'(exp_lat));
    @(negedge clk);
    chk_en = 1'b0;
    check({nm, "_ct_writes"}, 32'(wr_cnt), 32'(int'(exp_len) + 1));
    check({nm, "_s_writes"}, 32'(sw_cnt), 32'(2 * int'(exp_len)));
    check({nm, "_nonprint"}, 32'(pt_nonprint), 32'(exp_np));
    check({nm, "_nonprint_off"}, 32'(d1_pt_nonprint), 32'(0));
    nbad = 0;
    for (int k = 0; k <= int'(exp_len); k++) if (ct_mem[k] !== exp_ct[k]) nbad++;
    check({nm, "_ct_ram_bad_bytes"}, 32'(nbad), 32'(0));
    nbad = 0;
    for (int k = 0; k < 256; k++) if (s_mem[k] !== m_s[k]) nbad++;
    check({nm, "_s_ram_bad_bytes"}, 32'(nbad), 32'(0));
    if (exp_len != 8'hFF) check({nm, "_ct_tail"}, 32'(ct_mem[int'(exp_len) + 1]), 32'(8'hEE));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n  = 1'b0;
    en     = 1'b0;
    h_we   = 1'b0;
    h_addr = 8'h00;
    h_s    = 8'h00;
    h_pt   = 8'h00;
    h_ct   = 8'h00;

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (prev_rdy && !rdy) begin
            wr_cnt = 0;
            sw_cnt = 0;
          end
          if (chk_en) begin
            check("one_wren", 32'(s_wren & ct_wren), 32'(0));
            check("twin", {5'd0, d1_rdy, d1_s_wren, d1_ct_wren, d1_s_addr, d1_s_wrdata, d1_ct_wrdata},
                          {5'd0, rdy, s_wren, ct_wren, s_addr, s_wrdata, ct_wrdata});
            if (s_wren) sw_cnt++;
            if (ct_wren) begin
              check("ct_addr", 32'(ct_addr), 32'(wr_cnt[7:0]));
              check("ct_data", 32'(ct_wrdata), 32'(exp_ct[wr_cnt[7:0]]));
              wr_cnt++;
            end
          end
          prev_rdy = rdy;
        end else begin
          prev_rdy = 1'b1;
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_rdy", 32'(rdy), 32'(1));
    check("rst_wren", {30'd0, s_wren, ct_wren}, 32'(0));
    check("rst_addr", {s_addr, pt_addr, ct_addr, 8'h00}, 32'(0));
    check("rst_wrdata", {16'd0, s_wrdata, ct_wrdata}, 32'(0));
    check("rst_nonprint", 32'(pt_nonprint), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Pin the model against the published "Key"/"Plaintext" vector
    fill_pt(8'd9);
    for (int k = 0; k < 9; k++) m_pt[k + 1] = pv[k];
    model_ksa();
    model_run();
    for (int k = 0; k < 9; k++) check("model_known_vector", 32'(exp_ct[k + 1]), 32'(kv[k]));

    fill_pt(8'd0);
    run_case("len0", 1'b0, 3);

    fill_pt(8'd9);
    for (int k = 0; k < 9; k++) m_pt[k + 1] = pv[k];
    run_case("known", 1'b0, 66);
    check("known_ct0", 32'(ct_mem[0]), 32'(8'h09));
    for (int k = 0; k < 9; k++) check("known_ct", 32'(ct_mem[k + 1]), 32'(kv[k]));

    // Round trip: encrypting the ciphertext under a fresh KSA recovers the text
    for (int a = 0; a < 256; a++) rt[a] = ct_mem[a];
    for (int a = 0; a < 256; a++) m_pt[a] = rt[a];
    run_case("roundtrip", 1'b0, 66);
    for (int k = 0; k < 9; k++) check("roundtrip_pt", 32'(ct_mem[k + 1]), 32'(pv[k]));

    fill_pt(8'd2);
    m_pt[1] = 8'h41; m_pt[2] = 8'h0A;
    run_case("nonprint", 1'b0, 17);
    check("nonprint_set", 32'(pt_nonprint), 32'(1));

    fill_pt(8'd2);
    m_pt[1] = 8'h20; m_pt[2] = 8'h7E;
    run_case("print_edges", 1'b0, 17);
    check("print_edges_clear", 32'(pt_nonprint), 32'(0));

    fill_pt(8'd3);
    m_pt[1] = 8'h21; m_pt[2] = 8'h7F; m_pt[3] = 8'h7D;
    run_case("nonprint_7f", 1'b0, 24);

    fill_pt(8'd3);
    m_pt[1] = 8'h1F; m_pt[2] = 8'h30; m_pt[3] = 8'h40;
    run_case("nonprint_1f", 1'b0, 24);

    fill_pt(8'd255);
    run_case("len255", 1'b1, 1788);
    check("len255_last_ct", 32'(ct_mem[255]), 32'(exp_ct[255]));

    fill_pt(8'd9);
    for (int k = 0; k < 9; k++) m_pt[k + 1] = pv[k];
    run_case("en_pulse", 1'b1, 66);

    // Reset while sitting in WR_J (first S write of the run)
    fill_pt(8'd9);
    model_ksa();
    load_mems();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (s_wren) break;
    end
    check("rst_mid_found_wrj", 32'(s_wren), 32'(1));
    rst_n = 1'b0;
    #1;
    check("rst_mid_s_wren", 32'(s_wren), 32'(0));
    check("rst_mid_rdy", 32'(rdy), 32'(1));
    check("rst_mid_ct_wren", 32'(ct_wren), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 9; k++) m_pt[k + 1] = pv[k];
    run_case("after_rst", 1'b0, 66);
    for (int k = 0; k < 9; k++) check("after_rst_ct", 32'(ct_mem[k + 1]), 32'(kv[k]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
